// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory initiator. Runs one load or store at a
// time on a req/gnt/rvalid bus, formats store lanes, extends load data, and
// stalls the upstream pipeline while an access is outstanding.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid_in,
    input  logic [31:0] ex_alu_result_in,
    input  logic [31:0] ex_rs2_data_in,
    input  logic [4:0]  ex_rd_addr_in,
    input  logic [31:0] ex_pc_plus_4_in,
    input  logic [2:0]  ex_funct3_in,
    input  logic        ex_mem_read_in,
    input  logic        ex_mem_write_in,
    input  logic        ex_reg_write_in,
    input  logic        ex_mem_to_reg_in,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic [31:0] mem_alu_result_out,
    output logic [4:0]  mem_rd_addr_out,
    output logic [31:0] mem_pc_plus_4_out,
    output logic [31:0] mem_read_data_out,
    output logic        mem_reg_write_out,
    output logic        mem_mem_to_reg_out,
    output logic        mem_stall_out,
    output logic        mem_misaligned_out,
    output logic        mem_err_out
);

    // Counter must be able to hold TIMEOUT_CYCLES after a late grant.
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             bus_req_q, bus_req_d;
    logic             bus_we_q, bus_we_d;
    logic [31:0]      bus_addr_q, bus_addr_d;
    logic [31:0]      bus_wdata_q, bus_wdata_d;
    logic [3:0]       bus_be_q, bus_be_d;

    logic        mem_op;
    logic        addr_misaligned;
    logic        misaligned;
    logic        stall;
    logic        timeout_hit;
    logic [1:0]  byte_off;
    logic [31:0] rdata_shifted;
    logic [31:0] load_ext;
    logic [31:0] wdata_fmt;
    logic [3:0]  be_fmt;

    assign byte_off      = ex_alu_result_in[1:0];
    assign mem_op        = ex_valid_in & (ex_mem_read_in | ex_mem_write_in);
    assign misaligned    = mem_op & addr_misaligned;
    assign rdata_shifted = bus_rdata >> {byte_off, 3'b000};
    assign timeout_hit   = (cnt_q >= CNT_LAST);

    // Size decode: store lane replication, byte enables, load extension, alignment.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        addr_misaligned = 1'b0;
        wdata_fmt       = ex_rs2_data_in;
        be_fmt          = 4'b1111;
        load_ext        = rdata_shifted;
        unique case (ex_funct3_in[1:0])
            2'b00: begin
                wdata_fmt = {4{ex_rs2_data_in[7:0]}};
                be_fmt    = 4'b0001 << byte_off;
                load_ext  = {{24{~ex_funct3_in[2] & rdata_shifted[7]}}, rdata_shifted[7:0]};
            end
            2'b01: begin
                addr_misaligned = byte_off[0];
                wdata_fmt       = {2{ex_rs2_data_in[15:0]}};
                be_fmt          = 4'b0011 << byte_off;
                load_ext        = {{16{~ex_funct3_in[2] & rdata_shifted[15]}}, rdata_shifted[15:0]};
            end
            default: begin
                addr_misaligned = |byte_off;
            end
        endcase
    end

    // Next-state, bus register loads and stall for the access FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        stall       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (mem_op && !addr_misaligned) begin
                    stall       = 1'b1;
                    state_d     = S_REQ;
                    cnt_d       = '0;
                    err_d       = 1'b0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = ex_mem_write_in;
                    bus_addr_d  = {ex_alu_result_in[31:2], 2'b00};
                    bus_wdata_d = ex_mem_write_in ? wdata_fmt : 32'h0;
                    bus_be_d    = ex_mem_write_in ? be_fmt : 4'b1111;
                end
            end
            S_REQ: begin
                stall = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (bus_gnt && bus_rvalid) begin
                    bus_req_d = 1'b0;
                    state_d   = S_DONE;
                    if (!bus_we_q) rdata_d = load_ext;
                end else if (bus_gnt) begin
                    bus_req_d = 1'b0;
                    state_d   = S_WAIT;
                end else if (timeout_hit) begin
                    bus_req_d = 1'b0;
                    rdata_d   = 32'h0;
                    err_d     = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (bus_rvalid) begin
                    state_d = S_DONE;
                    if (!bus_we_q) rdata_d = load_ext;
                end else if (timeout_hit) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and bus registers; reset also abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            rdata_q     <= 32'h0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            bus_be_q    <= 4'b0000;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_be    = bus_be_q;

    assign mem_alu_result_out = ex_alu_result_in;
    assign mem_rd_addr_out    = ex_rd_addr_in;
    assign mem_pc_plus_4_out  = ex_pc_plus_4_in;
    assign mem_mem_to_reg_out = ex_mem_to_reg_in;
    assign mem_read_data_out  = rdata_q;
    assign mem_stall_out      = stall;
    assign mem_misaligned_out = misaligned;
    assign mem_err_out        = (state_q == S_DONE) & err_q;
    // The MEM/WB buffer captures every cycle, so stalls and failures become bubbles.
    assign mem_reg_write_out  = ex_reg_write_in & ex_valid_in & ~stall & ~misaligned & ~mem_err_out;

endmodule
